// File: rtl/mem_ctrl_mc.sv
// Multi-channel system-to-memory controller.
// Round-robin arbitration over NUM_CH requestors, one access at a time to a
// synchronous memory core with RD_LAT cycles of read latency. Out-of-range
// addresses are completed with err_sys instead of being issued.
module mem_ctrl_mc #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned MEM_DEPTH = 2**ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        cmd_valid_sys,
  input  logic [NUM_CH-1:0]        we_sys,
  input  logic [NUM_CH*ADDR_W-1:0] addr_sys,
  input  logic [NUM_CH*DATA_W-1:0] wdata_sys,
  output logic [NUM_CH-1:0]        ready_sys,
  output logic [NUM_CH-1:0]        rvalid_sys,
  output logic                     err_sys,
  output logic [DATA_W-1:0]        rdata_sys,
  output logic                     ce_mem,
  output logic                     we_mem,
  output logic [ADDR_W-1:0]        addr_mem,
  output logic [DATA_W-1:0]        datai_mem,
  input  logic [DATA_W-1:0]        datao_mem
);

  localparam int unsigned     PTR_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C   = MEM_DEPTH[ADDR_W:0];
  localparam logic [2:0]      LAST_WAIT = 3'(RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

  state_t              state, state_nx;
  logic [PTR_W-1:0]    ptr, ptr_nx;
  logic [PTR_W-1:0]    grant, grant_nx;
  logic                lat_we, lat_we_nx;
  logic                lat_oor, lat_oor_nx;
  logic [2:0]          cnt, cnt_nx;

  logic                ce_nx, we_nx, err_nx;
  logic [ADDR_W-1:0]   addr_nx;
  logic [DATA_W-1:0]   datai_nx, rdata_nx;
  logic [NUM_CH-1:0]   ready_nx, rvalid_nx;

  logic [ADDR_W-1:0]   addr_ch  [NUM_CH];
  logic [DATA_W-1:0]   wdata_ch [NUM_CH];
  logic                req_found;
  logic [PTR_W-1:0]    req_sel;
  logic [PTR_W-1:0]    idx;
  logic                sel_oor;
  logic [NUM_CH-1:0]   grant_oh;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_split
    assign addr_ch[gi]  = addr_sys[gi*ADDR_W +: ADDR_W];
    assign wdata_ch[gi] = wdata_sys[gi*DATA_W +: DATA_W];
  end

  assign sel_oor  = {1'b0, addr_ch[req_sel]} >= DEPTH_C;
  assign grant_oh = NUM_CH'(1) << grant;

  // Round-robin search: first requester at or above the pointer, wrapping.
  always_comb begin
    req_found = 1'b0;
    req_sel   = '0;
    idx       = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = PTR_W'((32'(ptr) + i) % NUM_CH);
      if (!req_found && cmd_valid_sys[idx]) begin
        req_found = 1'b1;
        req_sel   = idx;
      end
    end
  end

  // Next state plus next values of every registered output.
  // Outputs are registered, so each one is computed for the state being entered.
  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    grant_nx   = grant;
    lat_we_nx  = lat_we;
    lat_oor_nx = lat_oor;
    cnt_nx     = cnt;
    ce_nx      = 1'b0;
    we_nx      = 1'b0;
    err_nx     = 1'b0;
    addr_nx    = addr_mem;
    datai_nx   = datai_mem;
    rdata_nx   = rdata_sys;
    ready_nx   = '0;
    rvalid_nx  = '0;
    unique case (state)
      IDLE: begin
        if (req_found) begin
          grant_nx   = req_sel;
          lat_we_nx  = we_sys[req_sel];
          lat_oor_nx = sel_oor;
          // addr/wdata are latched into the memory-side registers even when
          // out of range; ce_mem stays low so the memory never sees them.
          addr_nx    = addr_ch[req_sel];
          datai_nx   = wdata_ch[req_sel];
          ce_nx      = !sel_oor;
          we_nx      = !sel_oor && we_sys[req_sel];
          state_nx   = ISSUE;
        end
      end
      ISSUE: begin
        cnt_nx = '0;
        if (!lat_oor && !lat_we) begin
          state_nx = WAIT_RD;
        end else begin
          state_nx = DONE;
          ready_nx = grant_oh;
          err_nx   = lat_oor;
        end
      end
      WAIT_RD: begin
        if (cnt == LAST_WAIT) begin
          rdata_nx  = datao_mem;
          ready_nx  = grant_oh;
          rvalid_nx = grant_oh;
          state_nx  = DONE;
        end else begin
          cnt_nx = cnt + 3'd1;
        end
      end
      DONE: begin
        ptr_nx   = (32'(grant) == NUM_CH - 1) ? '0 : grant + 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Arbiter pointer, command latch, wait counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr        <= '0;
      grant      <= '0;
      lat_we     <= 1'b0;
      lat_oor    <= 1'b0;
      cnt        <= '0;
      ce_mem     <= 1'b0;
      we_mem     <= 1'b0;
      err_sys    <= 1'b0;
      addr_mem   <= '0;
      datai_mem  <= '0;
      rdata_sys  <= '0;
      ready_sys  <= '0;
      rvalid_sys <= '0;
    end else begin
      ptr        <= ptr_nx;
      grant      <= grant_nx;
      lat_we     <= lat_we_nx;
      lat_oor    <= lat_oor_nx;
      cnt        <= cnt_nx;
      ce_mem     <= ce_nx;
      we_mem     <= we_nx;
      err_sys    <= err_nx;
      addr_mem   <= addr_nx;
      datai_mem  <= datai_nx;
      rdata_sys  <= rdata_nx;
      ready_sys  <= ready_nx;
      rvalid_sys <= rvalid_nx;
    end
  end

endmodule
